// File: rtl/fc_layer.sv
// Fully-connected output layer: streams one feature element per beat with a weight
// per class, multiply-accumulates per class and presents saturated sums with a done level.
module fc_layer #(
  parameter int CLASSIFICATIONS = 10,
  parameter int ELEMENT_SIZE    = 30,
  parameter int NUM_INPUTS      = 1024,
  parameter int FEATURE_SIZE    = 8,
  parameter int WEIGHT_SIZE     = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [FEATURE_SIZE-1:0]                 feature_in,
  input  logic [CLASSIFICATIONS*WEIGHT_SIZE-1:0]  weights_in,
  output logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0] fc_results,
  output logic                                    done
);

  localparam int PROD_W = FEATURE_SIZE + WEIGHT_SIZE;
  localparam int ACC_W  = ELEMENT_SIZE + 2;
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {3'b000, {(ELEMENT_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {3'b111, {(ELEMENT_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                                  r_state;
  state_t                                  w_next;
  logic [CNT_W-1:0]                        r_cnt;
  logic signed [ACC_W-1:0]                 r_acc [CLASSIFICATIONS];
  logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0] r_results;

  logic signed [PROD_W-1:0]                w_prod [CLASSIFICATIONS];
  logic signed [ACC_W-1:0]                 w_sum  [CLASSIFICATIONS];
  logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0] w_sat_bus;
  logic                                    w_accept;
  logic                                    w_last;

  function automatic logic [ELEMENT_SIZE-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[ELEMENT_SIZE-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[ELEMENT_SIZE-1:0];
    else
      return v[ELEMENT_SIZE-1:0];
  endfunction

  assign w_accept = in_valid && (r_state == S_ACCUM);
  assign w_last   = w_accept && (r_cnt == CNT_W'(NUM_INPUTS - 1));

  // Per-class signed product and running sum; the sum feeds both the accumulator
  // and the output saturator so the final beat needs no extra cycle.
  always_comb begin
    w_sat_bus = '0;
    for (int c = 0; c < CLASSIFICATIONS; c++) begin
      w_prod[c] = PROD_W'($signed(feature_in)) *
                  PROD_W'($signed(weights_in[c*WEIGHT_SIZE +: WEIGHT_SIZE]));
      w_sum[c]  = r_acc[c] + ACC_W'(w_prod[c]);
      w_sat_bus[c*ELEMENT_SIZE +: ELEMENT_SIZE] = saturate(w_sum[c]);
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!en) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_results <= '0;
      for (int c = 0; c < CLASSIFICATIONS; c++) r_acc[c] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && en) begin
        r_cnt <= '0;
        for (int c = 0; c < CLASSIFICATIONS; c++) r_acc[c] <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int c = 0; c < CLASSIFICATIONS; c++) r_acc[c] <= w_sum[c];
      end
      // Results persist across IDLE; only a completed run or reset replaces them.
      if (w_last) r_results <= w_sat_bus;
    end
  end

  assign fc_results = r_results;

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: a 30-bit-result instance and a 16-bit-result instance
// share all inputs so the same vectors exercise both exact sums and saturation.
module tb_fc_layer;

  localparam int NC = 10;
  localparam int NI = 4;
  localparam int EA = 30;
  localparam int ES = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            in_valid;
  logic [7:0]      feature_in;
  logic [NC*8-1:0] weights_in;
  logic            ready_a, done_a, ready_s, done_s;
  logic [NC*EA-1:0] res_a;
  logic [NC*ES-1:0] res_s;

  always #5 clk = ~clk;

  fc_layer #(.CLASSIFICATIONS(NC), .ELEMENT_SIZE(EA), .NUM_INPUTS(NI),
             .FEATURE_SIZE(8), .WEIGHT_SIZE(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ready_a),
    .feature_in(feature_in), .weights_in(weights_in), .fc_results(res_a), .done(done_a));

  // 16-bit results keep the 18-bit accumulator wide enough for 4 full-scale products,
  // so clamping is exercised without internal wrap.
  fc_layer #(.CLASSIFICATIONS(NC), .ELEMENT_SIZE(ES), .NUM_INPUTS(NI),
             .FEATURE_SIZE(8), .WEIGHT_SIZE(8)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ready_s),
    .feature_in(feature_in), .weights_in(weights_in), .fc_results(res_s), .done(done_s));

  typedef struct {
    string name;
    int    feat [NI];
    int    wgt  [NC];
    int    exp_a[NC];
    int    exp_s[NC];
    logic [15:0] vpat;
    int    npat;
  } vec_t;

  vec_t tbl[7];
  int n_pass  = 0;
  int n_total = 0;
  int done_rises = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (done_a && !done_prev) done_rises++;
    done_prev <= done_a;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic longint get_a(input int c);
    logic signed [EA-1:0] t;
    t = res_a[c*EA +: EA];
    return longint'(t);
  endfunction

  function automatic longint get_s(input int c);
    logic signed [ES-1:0] t;
    t = res_s[c*ES +: ES];
    return longint'(t);
  endfunction

  task automatic set_weights(input int w[NC]);
    for (int c = 0; c < NC; c++) weights_in[c*8 +: 8] = 8'(w[c]);
  endtask

  // Called right after a falling edge; en rises immediately so a run can start on
  // the edge following an en-low edge.
  task automatic run_vec(input vec_t v);
    int beats;
    int cyc;
    logic vb;
    en = 1'b1;
    @(negedge clk);
    check({v.name, "_start_ready"}, ready_a, 1);
    check({v.name, "_start_done"}, done_a, 0);
    set_weights(v.wgt);
    beats = 0;
    cyc   = 0;
    while (beats < NI && cyc < 64) begin
      vb = (cyc < v.npat) ? v.vpat[cyc] : 1'b1;
      in_valid   = vb;
      feature_in = 8'(v.feat[beats]);
      @(negedge clk);
      if (vb) beats++;
      if (beats < NI) check({v.name, "_early_done"}, done_a, 0);
      cyc++;
    end
    check({v.name, "_beats"}, beats, NI);
    in_valid = 1'b0;
    check({v.name, "_done"}, done_a, 1);
    check({v.name, "_ready_low"}, ready_a, 0);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_a_c%0d", v.name, c), get_a(c), v.exp_a[c]);
      check($sformatf("%s_s_c%0d", v.name, c), get_s(c), v.exp_s[c]);
    end
    // Beats offered in DONE with en still high must be ignored.
    in_valid   = 1'b1;
    feature_in = 8'd50;
    @(negedge clk);
    check({v.name, "_hold_done"}, done_a, 1);
    check({v.name, "_hold_ready"}, ready_a, 0);
    check({v.name, "_hold_c9"}, get_a(9), v.exp_a[9]);
    in_valid = 1'b0;
    en       = 1'b0;
    @(negedge clk);
    check({v.name, "_drop_done"}, done_a, 0);
    check({v.name, "_idle_ready"}, ready_a, 0);
    check({v.name, "_idle_keep_c9"}, get_a(9), v.exp_a[9]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0 basic, 1 signed, 2 stalls, 3 basic after reset, 4 second run, 5 saturation, 6 mixed
    tbl[0].name = "basic";  tbl[0].feat = '{1, 1, 1, 1};   tbl[0].npat = 0; tbl[0].vpat = '0;
    tbl[1].name = "signed"; tbl[1].feat = '{3, -2, 5, -1}; tbl[1].npat = 0; tbl[1].vpat = '0;
    tbl[2].name = "stall";  tbl[2].feat = '{1, 1, 1, 1};   tbl[2].npat = 7; tbl[2].vpat = 16'b110_1001;
    tbl[3].name = "rerun";  tbl[3].feat = '{1, 1, 1, 1};   tbl[3].npat = 0; tbl[3].vpat = '0;
    tbl[4].name = "run2";   tbl[4].feat = '{2, 2, 2, 2};   tbl[4].npat = 0; tbl[4].vpat = '0;
    tbl[5].name = "sat";    tbl[5].feat = '{127, 127, 127, 127}; tbl[5].npat = 0; tbl[5].vpat = '0;
    tbl[6].name = "mixed";  tbl[6].feat = '{-4, 7, 0, 10}; tbl[6].npat = 0; tbl[6].vpat = '0;
    for (int c = 0; c < NC; c++) begin
      tbl[0].wgt[c] = c;     tbl[0].exp_a[c] = 4 * c;
      tbl[1].wgt[c] = c - 5; tbl[1].exp_a[c] = 5 * (c - 5);
      tbl[2].wgt[c] = c;     tbl[2].exp_a[c] = 4 * c;
      tbl[3].wgt[c] = c;     tbl[3].exp_a[c] = 4 * c;
      tbl[4].wgt[c] = c;     tbl[4].exp_a[c] = 8 * c;
      tbl[5].wgt[c] = 0;     tbl[5].exp_a[c] = 0;
      tbl[6].wgt[c] = c - 3; tbl[6].exp_a[c] = 13 * (c - 3);
    end
    tbl[5].wgt[0] = 127;  tbl[5].exp_a[0] = 64516;
    tbl[5].wgt[1] = -128; tbl[5].exp_a[1] = -65024;
    for (int i = 0; i < 7; i++) tbl[i].exp_s = tbl[i].exp_a;
    tbl[5].exp_s[0] = 32767;
    tbl[5].exp_s[1] = -32768;

    rst = 1'b0; en = 1'b0; in_valid = 1'b0; feature_in = '0; weights_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready_a, 0);
    check("rst_done", done_a, 0);
    check("rst_res_a", (res_a == '0), 1);
    check("rst_res_s", (res_s == '0), 1);
    rst = 1'b1;

    // Valid beats in IDLE are ignored.
    in_valid = 1'b1; feature_in = 8'd100; weights_in = {NC{8'd1}};
    repeat (2) @(negedge clk);
    check("idle_ready", ready_a, 0);
    check("idle_done", done_a, 0);
    in_valid = 1'b0;

    run_vec(tbl[0]);
    run_vec(tbl[1]);
    run_vec(tbl[2]);

    // Reset after two accepted beats discards the run and clears results.
    en = 1'b1;
    @(negedge clk);
    set_weights(tbl[0].wgt);
    in_valid = 1'b1; feature_in = 8'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_done", done_a, 0);
    check("midrst_ready", ready_a, 0);
    for (int c = 0; c < NC; c++) check($sformatf("midrst_a_c%0d", c), get_a(c), 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_after_ready", ready_a, 0);

    run_vec(tbl[3]);
    run_vec(tbl[4]);
    run_vec(tbl[5]);
    check("sat_s_done", done_s, 0);
    run_vec(tbl[6]);

    check("done_pulses", done_rises, 7);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
